// File: rtl/fir_sym_lpf_pkg.sv
// Shared sizing helpers and reset coefficient values for the symmetric FIR.
// Width helpers are functions so each instance can size itself from its own parameters.
package fir_pkg;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_TAPS       = 3;
   localparam int DEF_COEF_W     = 8;
   localparam int DEF_COEF_SHIFT = 6;

   function automatic int ncoef(input int taps);
      return (taps + 1) / 2;
   endfunction

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int pre_w(input int data_w);
      return data_w + 1;
   endfunction

   function automatic int prod_w(input int data_w, input int coef_w);
      return pre_w(data_w) + coef_w;
   endfunction

   function automatic int sum_w(input int data_w, input int coef_w, input int taps);
      return prod_w(data_w, coef_w) + clog2(ncoef(taps));
   endfunction

   localparam int PRE_W  = pre_w(DEF_DATA_W);
   localparam int PROD_W = prod_w(DEF_DATA_W, DEF_COEF_W);
   localparam int SUM_W  = sum_w(DEF_DATA_W, DEF_COEF_W, DEF_TAPS);

   // Unity weight on the centre tap only: the filter resets to a pure delay.
   function automatic int default_coef(input int k, input int taps, input int shift);
      return (k == ncoef(taps) - 1) ? (1 << shift) : 0;
   endfunction

endpackage

// File: rtl/fir_sym_lpf_if.sv
// Pixel stream, coefficient write port and filtered output of the symmetric FIR.
interface fir_sym_lpf_if #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] yin;
   logic [DATA_W-1:0] cin;
   logic              coef_we;
   logic [3:0]        coef_addr;
   logic [COEF_W-1:0] coef_data;
   logic              out_valid;
   logic [DATA_W-1:0] yout;
   logic [DATA_W-1:0] cout;

   modport master (
      output in_valid, yin, cin, coef_we, coef_addr, coef_data,
      input  out_valid, yout, cout
   );

   modport slave (
      input  in_valid, yin, cin, coef_we, coef_addr, coef_data,
      output out_valid, yout, cout
   );
endinterface

// File: rtl/fir_tap_line.sv
// Enable-gated shift register with every stage visible; stage 0 is the newest sample.
module fir_tap_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_taps [DEPTH]
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (i_en) begin
         r_stage[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_taps = r_stage;

endmodule

// File: rtl/fir_sym_lpf.sv
// Symmetric odd-length FIR low-pass for luma with loadable coefficients, rounding and
// saturation; chroma rides a matched delay so it stays aligned with the centre luma tap.
module fir_sym_lpf
   import fir_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int TAPS       = 3,
   parameter int COEF_W     = 8,
   parameter int COEF_SHIFT = 6
) (
   input logic          clk,
   input logic          rst,
   fir_sym_lpf_if.slave bus
);

   localparam int NCOEF   = ncoef(TAPS);
   localparam int MID     = (TAPS - 1) / 2;
   localparam int PRE_WL  = pre_w(DATA_W);
   localparam int PROD_WL = prod_w(DATA_W, COEF_W);
   localparam int SUM_WL  = sum_w(DATA_W, COEF_W, TAPS);

   localparam logic [SUM_WL:0] RND  = (SUM_WL+1)'(1) << (COEF_SHIFT - 1);
   localparam logic [SUM_WL:0] YMAX = (SUM_WL+1)'((1 << DATA_W) - 1);

   logic [DATA_W-1:0]  w_tap    [TAPS];
   logic [DATA_W-1:0]  w_chroma [MID+1];
   logic [PRE_WL-1:0]  w_pre    [NCOEF];
   logic [PROD_WL-1:0] w_prod   [NCOEF];
   logic [SUM_WL-1:0]  w_sum;
   logic [SUM_WL:0]    w_rnd;
   logic [SUM_WL:0]    w_shift;
   logic [DATA_W-1:0]  w_sat;

   logic [COEF_W-1:0]  r_coef [NCOEF];
   logic [PROD_WL-1:0] r_prod [NCOEF];
   logic [DATA_W-1:0]  r_c1;
   logic               r_v0;
   logic               r_v1;
   logic               r_v2;
   logic [DATA_W-1:0]  r_yout;
   logic [DATA_W-1:0]  r_cout;

   // S0: luma taps and chroma alignment line both advance only on accepted samples.
   fir_tap_line #(
      .WIDTH (DATA_W),
      .DEPTH (TAPS)
   ) u_luma_line (
      .clk    (clk),
      .rst    (rst),
      .i_en   (bus.in_valid),
      .i_d    (bus.yin),
      .o_taps (w_tap)
   );

   fir_tap_line #(
      .WIDTH (DATA_W),
      .DEPTH (MID + 1)
   ) u_chroma_line (
      .clk    (clk),
      .rst    (rst),
      .i_en   (bus.in_valid),
      .i_d    (bus.cin),
      .o_taps (w_chroma)
   );

   // Coefficient bank; addresses at or beyond NCOEF match no entry and are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NCOEF; k++) r_coef[k] <= COEF_W'(default_coef(k, TAPS, COEF_SHIFT));
      end else if (bus.coef_we) begin
         for (int k = 0; k < NCOEF; k++) begin
            if (bus.coef_addr == 4'(k)) r_coef[k] <= bus.coef_data;
         end
      end
   end

   for (genvar k = 0; k < NCOEF; k++) begin : g_mac
      if (k < MID) begin : g_pair
         assign w_pre[k] = PRE_WL'(w_tap[k]) + PRE_WL'(w_tap[TAPS-1-k]);
      end else begin : g_centre
         assign w_pre[k] = PRE_WL'(w_tap[k]);
      end
      assign w_prod[k] = PROD_WL'(w_pre[k]) * PROD_WL'(r_coef[k]);
   end

   // S1: products of the sample captured on the previous edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NCOEF; k++) r_prod[k] <= '0;
         r_c1 <= '0;
      end else if (r_v0) begin
         for (int k = 0; k < NCOEF; k++) r_prod[k] <= w_prod[k];
         r_c1 <= w_chroma[MID];
      end
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < NCOEF; k++) w_sum = w_sum + SUM_WL'(r_prod[k]);
   end

   assign w_rnd   = {1'b0, w_sum} + RND;
   assign w_shift = w_rnd >> COEF_SHIFT;
   assign w_sat   = (w_shift > YMAX) ? '1 : w_shift[DATA_W-1:0];

   // S2: outputs only move with a valid result, so they hold across gaps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_yout <= '0;
         r_cout <= '0;
      end else if (r_v1) begin
         r_yout <= w_sat;
         r_cout <= r_c1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v0 <= 1'b0;
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else begin
         r_v0 <= bus.in_valid;
         r_v1 <= r_v0;
         r_v2 <= r_v1;
      end
   end

   assign bus.out_valid = r_v2;
   assign bus.yout      = r_yout;
   assign bus.cout      = r_cout;

endmodule

// File: tb/tb_fir_sym_lpf.sv
// Self-checking bench for fir_sym_lpf: directed scenarios plus a randomized run against
// a sample-history reference model.
module tb_fir_sym_lpf;

   localparam int DATA_W = 8;
   localparam int TAPS   = 3;
   localparam int COEF_W = 8;
   localparam int SHIFT  = 6;
   localparam int NCOEF  = (TAPS + 1) / 2;
   localparam int MID    = (TAPS - 1) / 2;

   logic clk;
   logic rst;

   fir_sym_lpf_if #(.DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();

   fir_sym_lpf #(
      .DATA_W     (DATA_W),
      .TAPS       (TAPS),
      .COEF_W     (COEF_W),
      .COEF_SHIFT (SHIFT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit v;
      int y;
      int c;
   } ent_t;

   int   hist  [TAPS];
   int   chist [TAPS];
   int   mcoef [NCOEF];
   ent_t pipe  [$];
   bit   exp_v;
   int   exp_y;
   int   exp_c;
   int   total;
   int   bad;

   task automatic model_reset();
      for (int i = 0; i < TAPS; i++) begin
         hist[i]  = 0;
         chist[i] = 0;
      end
      for (int k = 0; k < NCOEF; k++) mcoef[k] = (k == NCOEF - 1) ? (1 << SHIFT) : 0;
      pipe.delete();
      pipe.push_back('{0, 0, 0});
      pipe.push_back('{0, 0, 0});
      exp_v = 0;
      exp_y = 0;
      exp_c = 0;
   endtask

   function automatic int model_y();
      int s;
      s = 0;
      for (int k = 0; k < NCOEF; k++) begin
         if (k == MID) s += mcoef[k] * hist[k];
         else          s += mcoef[k] * (hist[k] + hist[TAPS-1-k]);
      end
      s = (s + (1 << (SHIFT - 1))) >> SHIFT;
      return (s > 255) ? 255 : s;
   endfunction

   // Drive one cycle of inputs, advance the model by one edge, end at the next falling edge.
   task automatic step(input bit v, input int y, input int c,
                       input bit we = 1'b0, input int addr = 0, input int data = 0);
      ent_t e;
      bus.in_valid  = v;
      bus.yin       = 8'(y);
      bus.cin       = 8'(c);
      bus.coef_we   = we;
      bus.coef_addr = 4'(addr);
      bus.coef_data = 8'(data);
      @(posedge clk);
      if (we && addr < NCOEF) mcoef[addr] = data;
      e = '{0, 0, 0};
      if (v) begin
         for (int i = TAPS - 1; i > 0; i--) begin
            hist[i]  = hist[i-1];
            chist[i] = chist[i-1];
         end
         hist[0]  = y;
         chist[0] = c;
         e = '{1, model_y(), chist[MID]};
      end
      pipe.push_back(e);
      e = pipe.pop_front();
      exp_v = e.v;
      if (e.v) begin
         exp_y = e.y;
         exp_c = e.c;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 0; bus.yin = 0; bus.cin = 0;
      bus.coef_we = 0; bus.coef_addr = 0; bus.coef_data = 0;
      repeat (2) @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_valid: got %0d expected 0", bus.out_valid);
      end
      total++;
      if (bus.yout !== 8'd0) begin
         bad++; $display("FAIL reset_yout: got %0d expected 0", bus.yout);
      end
      total++;
      if (bus.cout !== 8'd0) begin
         bad++; $display("FAIL reset_cout: got %0d expected 0", bus.cout);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_identity();
      int ys [$];
      int cs [$];
      int ey [4] = '{0, 10, 20, 30};
      int ec [4] = '{0, 1, 2, 3};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(i < 4, (i + 1) * 10, i + 1);
         total++;
         if (bus.out_valid !== exp_v) begin
            bad++; $display("FAIL ident_valid[%0d]: got %0d expected %0d", i, bus.out_valid, exp_v);
         end
         if (bus.out_valid) begin
            ys.push_back(int'(bus.yout));
            cs.push_back(int'(bus.cout));
         end
      end
      total++;
      if (ys.size() != 4) begin
         bad++; $display("FAIL ident_count: got %0d expected 4", ys.size());
      end
      for (int i = 0; i < 4 && i < ys.size(); i++) begin
         total++;
         if (ys[i] != ey[i] || cs[i] != ec[i]) begin
            bad++;
            $display("FAIL ident_out[%0d]: got y=%0d c=%0d expected y=%0d c=%0d", i, ys[i], cs[i], ey[i], ec[i]);
         end
      end
   endtask

   task automatic test_impulse(input int amp, input int e0, input int e1, input int e2, input int e3);
      int ys [$];
      int ey [4];
      ey = '{e0, e1, e2, e3};
      do_reset();
      step(0, 0, 0, 1'b1, 0, 16);
      step(0, 0, 0, 1'b1, 1, 32);
      for (int i = 0; i < 6; i++) begin
         step(i < 4, (i == 0) ? amp : 0, i);
         if (bus.out_valid) ys.push_back(int'(bus.yout));
      end
      total++;
      if (ys.size() != 4) begin
         bad++; $display("FAIL impulse%0d_count: got %0d expected 4", amp, ys.size());
      end
      for (int i = 0; i < 4 && i < ys.size(); i++) begin
         total++;
         if (ys[i] != ey[i]) begin
            bad++; $display("FAIL impulse%0d_y[%0d]: got %0d expected %0d", amp, i, ys[i], ey[i]);
         end
      end
   endtask

   task automatic test_saturation();
      int ys [$];
      do_reset();
      step(0, 0, 0, 1'b1, 0, 64);
      step(0, 0, 0, 1'b1, 1, 64);
      for (int i = 0; i < 5; i++) begin
         step(1, 255, 7);
         if (bus.out_valid) ys.push_back(int'(bus.yout));
      end
      step(0, 0, 0, 1'b1, 0, 0);
      if (bus.out_valid) ys.push_back(int'(bus.yout));
      step(0, 0, 0, 1'b1, 1, 0);
      if (bus.out_valid) ys.push_back(int'(bus.yout));
      for (int i = 0; i < 6; i++) begin
         step(i < 4, 255, 7);
         if (bus.out_valid) ys.push_back(int'(bus.yout));
      end
      total++;
      if (ys.size() != 9) begin
         bad++; $display("FAIL sat_count: got %0d expected 9", ys.size());
      end
      for (int i = 0; i < ys.size(); i++) begin
         total++;
         if (ys[i] != ((i < 5) ? 255 : 0)) begin
            bad++; $display("FAIL sat_y[%0d]: got %0d expected %0d", i, ys[i], (i < 5) ? 255 : 0);
         end
      end
   endtask

   task automatic test_gaps();
      bit pat [8] = '{1, 0, 0, 1, 1, 0, 0, 0};
      int ey  [3] = '{16, 32, 16};
      int ys  [$];
      int n;
      bit want;
      do_reset();
      step(0, 0, 0, 1'b1, 0, 16);
      step(0, 0, 0, 1'b1, 1, 32);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step(pat[i], (pat[i] && n == 0) ? 64 : 0, 9);
         if (pat[i]) n++;
         want = (i >= 2) ? pat[i-2] : 1'b0;
         total++;
         if (bus.out_valid !== want) begin
            bad++; $display("FAIL gap_valid[%0d]: got %0d expected %0d", i, bus.out_valid, want);
         end
         if (bus.out_valid) ys.push_back(int'(bus.yout));
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (i >= ys.size() || ys[i] != ey[i]) begin
            bad++;
            $display("FAIL gap_y[%0d]: got %0d expected %0d", i, (i < ys.size()) ? ys[i] : -1, ey[i]);
         end
      end
   endtask

   task automatic test_random();
      bit v;
      bit we;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 9) == 0);
         step(v, $urandom_range(0, 255), $urandom_range(0, 255),
              we, $urandom_range(0, 15), $urandom_range(0, 48));
         total++;
         if (bus.out_valid !== exp_v || int'(bus.yout) != exp_y || int'(bus.cout) != exp_c) begin
            bad++;
            $display("FAIL rand[%0d]: got v=%0d y=%0d c=%0d expected v=%0d y=%0d c=%0d",
                     i, bus.out_valid, bus.yout, bus.cout, exp_v, exp_y, exp_c);
         end
      end
   endtask

   task automatic test_reset_midstream();
      int ys [$];
      int ey [4] = '{0, 10, 20, 30};
      do_reset();
      step(0, 0, 0, 1'b1, 0, 16);
      step(0, 0, 0, 1'b1, 1, 32);
      for (int i = 0; i < 4; i++) step(1, 200, 50 + i);
      bus.in_valid  = 1'b1;
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'd5;
      bus.coef_data = 8'd99;
      rst = 1'b1;
      #2;
      total++;
      if (bus.out_valid !== 1'b0 || bus.yout !== 8'd0 || bus.cout !== 8'd0) begin
         bad++;
         $display("FAIL midrst_async: got v=%0d y=%0d c=%0d expected 0 0 0", bus.out_valid, bus.yout, bus.cout);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(0, 0, 0, 1'b1, 5, 77);
      for (int i = 0; i < 6; i++) begin
         step(i < 4, (i + 1) * 10, i + 1);
         total++;
         if (bus.out_valid !== exp_v || int'(bus.yout) != exp_y || int'(bus.cout) != exp_c) begin
            bad++;
            $display("FAIL midrst_model[%0d]: got v=%0d y=%0d c=%0d expected v=%0d y=%0d c=%0d",
                     i, bus.out_valid, bus.yout, bus.cout, exp_v, exp_y, exp_c);
         end
         if (bus.out_valid) ys.push_back(int'(bus.yout));
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (i >= ys.size() || ys[i] != ey[i]) begin
            bad++;
            $display("FAIL midrst_ident[%0d]: got %0d expected %0d", i, (i < ys.size()) ? ys[i] : -1, ey[i]);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_identity();
      test_impulse(64, 16, 32, 16, 0);
      test_impulse(2, 1, 1, 1, 0);
      test_saturation();
      test_gaps();
      test_random();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
